// File: rtl/fractal_worker.sv
// fractal_worker: escape-time Julia/Mandelbrot pixel worker with MC result handshake.
// Optional Mandelbrot initialisation is enabled by defining FRACTAL_MANDEL_EN.
// Ports:
//   clk, n_rst                 clock (rising edge), asynchronous active-low reset
//   x, y                       pixel column/row, latched on an accepted start
//   c_real_in, c_imag_in       Julia constant (signed fixed point)
//   mode                       0 = Julia, 1 = Mandelbrot (ignored unless FRACTAL_MANDEL_EN)
//   JW_start, JW_ready         start request / worker idle
//   JW_done, MC_busy           result valid / MC still consuming it
//   address, color, iter_count framebuffer byte address, pixel colour, escape count
module fractal_worker #(
    parameter int          WIDTH      = 22,
    parameter int          FRACTIONAL = 11,
    parameter int          MAX_ITER   = 256,
    parameter int          COORD_BITS = 10,
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          STEP       = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [COORD_BITS-1:0] x,
    input  logic [COORD_BITS-1:0] y,
    input  logic [WIDTH-1:0]      c_real_in,
    input  logic [WIDTH-1:0]      c_imag_in,
    input  logic                  mode,
    input  logic                  JW_start,
    input  logic                  MC_busy,
    output logic                  JW_ready,
    output logic                  JW_done,
    output logic [31:0]           address,
    output logic [31:0]           color,
    output logic [15:0]           iter_count
);
    typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;
    state_t state, state_n;
    logic [COORD_BITS-1:0] x_q, y_q;
    logic signed [WIDTH-1:0] cr, ci, zr, zi, px, py, zr_n, zi_n;
    logic [15:0] iter;
    logic signed [2*WIDTH-1:0] rr, ii;
    logic signed [2*WIDTH:0] sum, diff, zx;
    logic [31:0] addr_n;
    logic escape, last, mandel;

`ifdef FRACTAL_MANDEL_EN
    logic mode_q;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) mode_q <= 1'b0;
        else if (state == IDLE && JW_start) mode_q <= mode;
    assign mandel = mode_q;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign mandel = 1'b0;
`endif

    always_comb begin
        px     = WIDTH'(($signed(64'(x_q)) - 64'(SCREEN_W / 2)) * 64'(STEP));
        py     = WIDTH'(($signed(64'(y_q)) - 64'(SCREEN_H / 2)) * 64'(STEP));
        addr_n = BASE_ADDR + ((32'(y_q) * 32'(SCREEN_W) + 32'(x_q)) << 2);
        // Products kept at full width; the one-bit-wider sums cannot overflow.
        rr     = (2*WIDTH)'(zr) * (2*WIDTH)'(zr);
        ii     = (2*WIDTH)'(zi) * (2*WIDTH)'(zi);
        sum    = (2*WIDTH+1)'(rr) + (2*WIDTH+1)'(ii);
        diff   = (2*WIDTH+1)'(rr) - (2*WIDTH+1)'(ii);
        zx     = (2*WIDTH+1)'(zr) * (2*WIDTH+1)'(zi);
        escape = (sum >>> FRACTIONAL) > ((2*WIDTH+1)'(4) <<< FRACTIONAL);
        last   = iter == 16'(MAX_ITER - 1);
        zr_n   = WIDTH'(diff >>> FRACTIONAL) + cr;
        zi_n   = WIDTH'((zx <<< 1) >>> FRACTIONAL) + ci;
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = JW_start ? INIT : IDLE;
            INIT: state_n = ITER;
            ITER: state_n = (escape || last) ? DONE : ITER;
            DONE: state_n = MC_busy ? DONE : IDLE;
        endcase
    end

    always_comb begin
        JW_ready = state == IDLE;
        JW_done  = state == DONE;
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            x_q        <= '0;
            y_q        <= '0;
            cr         <= '0;
            ci         <= '0;
            zr         <= '0;
            zi         <= '0;
            iter       <= '0;
            address    <= '0;
            color      <= '0;
            iter_count <= '0;
        end else begin
            case (state)
                IDLE: if (JW_start) begin
                    x_q <= x;
                    y_q <= y;
                    cr  <= c_real_in;
                    ci  <= c_imag_in;
                end
                INIT: begin
                    zr      <= mandel ? '0 : px;
                    zi      <= mandel ? '0 : py;
                    cr      <= mandel ? px : cr;
                    ci      <= mandel ? py : ci;
                    iter    <= '0;
                    address <= addr_n;
                end
                ITER: if (escape) begin
                    iter_count <= iter;
                    color      <= {8'h00, iter[7:0], iter[7:0], iter[7:0]};
                end else if (last) begin
                    iter_count <= 16'(MAX_ITER);
                    color      <= '0;
                end else begin
                    zr   <= zr_n;
                    zi   <= zi_n;
                    iter <= iter + 16'd1;
                end
                DONE: ;
            endcase
        end
endmodule
